// File: rtl/serv_csr_irq.sv
// serv_csr_irq: bit-serial machine-mode CSR unit owning mstatus, mie, mip and mcause.
// Samples interrupt lines, resolves priority and applies trap/mret side effects.
module serv_csr_irq #(
  parameter int unsigned W              = 1,
  parameter int unsigned NIRQ           = 3,
  parameter string       RESET_STRATEGY = "MINI"
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_init,
  input  logic            i_en,
  input  logic            i_cnt_done,
  input  logic            i_trap,
  input  logic            i_mret,
  input  logic            i_e_op,
  input  logic            i_ebreak,
  input  logic            i_mem_op,
  input  logic            i_mem_cmd,
  input  logic [NIRQ-1:0] i_irq,
  input  logic            i_csr_en,
  input  logic [1:0]      i_csr_sel,
  input  logic [1:0]      i_csr_source,
  input  logic            i_csr_d_sel,
  input  logic [W-1:0]    i_rf_csr_out,
  input  logic [W-1:0]    i_csr_imm,
  input  logic [W-1:0]    i_rs1,
  output logic [W-1:0]    o_csr_in,
  output logic [W-1:0]    o_q,
  output logic            o_new_irq,
  output logic            o_irq_pending
);

  localparam int unsigned BEATS = 32 / W;
  localparam int unsigned CW    = $clog2(BEATS);

  logic [CW-1:0]   r_beat;
  logic            r_mst_mie;
  logic            r_mst_mpie;
  logic [NIRQ-1:0] r_mie;
  logic [NIRQ-1:0] r_mip;
  logic            r_mcause_int;
  logic [4:0]      r_mcause_code;
  logic            r_new_irq;
  logic [4:0]      r_irq_code;

  logic [4:0]      w_beat5;
  logic [4:0]      w_bit_ofs;
  logic [31:0]     w_mstatus32;
  logic [31:0]     w_mie32;
  logic [31:0]     w_mip32;
  logic [31:0]     w_mcause32;
  logic [31:0]     w_csr32;
  logic [W-1:0]    w_own;
  logic [W-1:0]    w_d;
  logic            w_wr;
  logic            w_trap;
  logic            w_mret;
  logic [NIRQ-1:0] w_pend;
  logic [4:0]      w_code;
  logic [4:0]      w_exc;
  logic            w_mst_mie_n;
  logic            w_mst_mpie_n;
  logic [NIRQ-1:0] w_mie_n;
  logic            w_mcause_int_n;
  logic [4:0]      w_mcause_code_n;
  logic            w_new_irq_n;
  logic [4:0]      w_irq_code_n;

  // Bit position in mie/mip of source k; equals its interrupt cause code.
  function automatic logic [4:0] irq_pos(input int unsigned k);
    if (k == 0)      return 5'd3;
    else if (k == 1) return 5'd7;
    else if (k == 2) return 5'd11;
    else             return 5'(k + 13);
  endfunction

  function automatic logic beat_hit(input logic [4:0] p, input logic [4:0] beat);
    return (p / 5'(W)) == beat;
  endfunction

  function automatic logic beat_pick(input logic [W-1:0] d, input logic [4:0] p);
    return 1'(d >> (p % 5'(W)));
  endfunction

  // Beat counter: restarts at 0 whenever the transfer is idle or completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 r_beat <= '0;
    else if (!i_en || i_cnt_done) r_beat <= '0;
    else                          r_beat <= r_beat + CW'(1);
  end

  assign w_beat5   = 5'(r_beat);
  assign w_bit_ofs = 5'(32'(r_beat) * W);
  assign w_wr      = i_csr_en & i_en;
  assign w_trap    = i_trap & i_cnt_done;
  assign w_mret    = i_mret & i_cnt_done;
  assign w_pend    = r_mip & r_mie;

  // 32-bit architectural views of the owned CSRs.
  always_comb begin
    w_mstatus32    = '0;
    w_mie32        = '0;
    w_mip32        = '0;
    w_mstatus32[3] = r_mst_mie;
    w_mstatus32[7] = r_mst_mpie;
    for (int unsigned k = 0; k < NIRQ; k++) begin
      w_mie32[irq_pos(k)] = r_mie[k];
      w_mip32[irq_pos(k)] = r_mip[k];
    end
    w_mcause32 = {r_mcause_int, 26'd0, r_mcause_code};
  end

  always_comb begin
    case (i_csr_sel)
      2'd0:    w_csr32 = w_mstatus32;
      2'd1:    w_csr32 = w_mie32;
      2'd2:    w_csr32 = w_mip32;
      default: w_csr32 = w_mcause32;
    endcase
  end

  assign w_own = W'(w_csr32 >> w_bit_ofs);
  assign o_q   = i_rf_csr_out | (w_wr ? w_own : '0);
  assign w_d   = i_csr_d_sel ? i_csr_imm : i_rs1;

  always_comb begin
    case (i_csr_source)
      2'd0:    o_csr_in = o_q;
      2'd1:    o_csr_in = w_d;
      2'd2:    o_csr_in = o_q | w_d;
      default: o_csr_in = o_q & ~w_d;
    endcase
  end

  // Priority: MEI > MSI > MTI > platform (highest platform index wins).
  always_comb begin
    w_code = '0;
    for (int unsigned k = 3; k < NIRQ; k++) begin
      if (w_pend[k]) w_code = irq_pos(k);
    end
    if (w_pend[1]) w_code = 5'd7;
    if (w_pend[0]) w_code = 5'd3;
    if (w_pend[2]) w_code = 5'd11;
  end

  always_comb begin
    w_exc = 5'd0;
    if (i_e_op)        w_exc = i_ebreak ? 5'd3 : 5'd11;
    else if (i_mem_op) w_exc = i_mem_cmd ? 5'd6 : 5'd4;
  end

  // Next state: CSR write first, then mret, then trap overriding the bits they touch.
  always_comb begin
    w_mst_mie_n     = r_mst_mie;
    w_mst_mpie_n    = r_mst_mpie;
    w_mie_n         = r_mie;
    w_mcause_int_n  = r_mcause_int;
    w_mcause_code_n = r_mcause_code;
    w_new_irq_n     = r_new_irq;
    w_irq_code_n    = r_irq_code;

    if (w_wr) begin
      case (i_csr_sel)
        2'd0: begin
          if (beat_hit(5'd3, w_beat5)) w_mst_mie_n  = beat_pick(o_csr_in, 5'd3);
          if (beat_hit(5'd7, w_beat5)) w_mst_mpie_n = beat_pick(o_csr_in, 5'd7);
        end
        2'd1: begin
          for (int unsigned k = 0; k < NIRQ; k++) begin
            if (beat_hit(irq_pos(k), w_beat5)) w_mie_n[k] = beat_pick(o_csr_in, irq_pos(k));
          end
        end
        2'd3: begin
          for (int unsigned b = 0; b < 5; b++) begin
            if (beat_hit(5'(b), w_beat5)) w_mcause_code_n[b] = beat_pick(o_csr_in, 5'(b));
          end
          if (beat_hit(5'd31, w_beat5)) w_mcause_int_n = beat_pick(o_csr_in, 5'd31);
        end
        default: ;
      endcase
    end

    if (w_trap) begin
      w_mst_mpie_n    = r_mst_mie;
      w_mst_mie_n     = 1'b0;
      w_mcause_int_n  = r_new_irq;
      w_mcause_code_n = r_new_irq ? r_irq_code : w_exc;
    end else if (w_mret) begin
      w_mst_mie_n  = r_mst_mpie;
      w_mst_mpie_n = 1'b1;
    end

    // A raised interrupt request is held until the trap that services it.
    if (w_trap) begin
      w_new_irq_n = 1'b0;
    end else if (i_cnt_done && !i_init && !r_new_irq) begin
      w_new_irq_n  = r_mst_mie & (|w_pend);
      w_irq_code_n = w_code;
    end
  end

  always_ff @(posedge i_clk) begin
    r_mcause_int  <= w_mcause_int_n;
    r_mcause_code <= w_mcause_code_n;
  end

  generate
    if (RESET_STRATEGY == "NONE") begin : g_noreset
      always_ff @(posedge i_clk) begin
        r_mst_mie  <= w_mst_mie_n;
        r_mst_mpie <= w_mst_mpie_n;
        r_mie      <= w_mie_n;
        r_mip      <= i_irq;
        r_new_irq  <= w_new_irq_n;
        r_irq_code <= w_irq_code_n;
      end
    end else begin : g_reset
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_mst_mie  <= 1'b0;
          r_mst_mpie <= 1'b0;
          r_mie      <= '0;
          r_mip      <= '0;
          r_new_irq  <= 1'b0;
          r_irq_code <= '0;
        end else begin
          r_mst_mie  <= w_mst_mie_n;
          r_mst_mpie <= w_mst_mpie_n;
          r_mie      <= w_mie_n;
          r_mip      <= i_irq;
          r_new_irq  <= w_new_irq_n;
          r_irq_code <= w_irq_code_n;
        end
      end
    end
  endgenerate

  assign o_new_irq     = r_new_irq;
  assign o_irq_pending = |w_pend;

endmodule
